// File: rtl/sim_ctrl_mmio.sv
// sim_ctrl_mmio: memory-mapped simulation/test controller on the CPU data bus.
// Provides halt with pass/fail code, a signature range, a cycle counter, a
// watchdog and an optional console FIFO (enabled by SIM_CTRL_CONSOLE_EN).
// Register k sits at BASE_ADDR + k*XLEN/8:
//   0 HALT (W), 1 SIG_BEGIN (RW), 2 SIG_END (RW), 3 CYCLE (R),
//   4 STATUS (R: halted, pass, timeout, con_overflow), 5 CONSOLE (W).
module sim_ctrl_mmio #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] BASE_ADDR      = XLEN'(32'h2000_0000),
    parameter int unsigned     TIMEOUT_CYCLES = 1000000,
    parameter int unsigned     CON_DEPTH      = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic            load,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            hit,
    output logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] sig_begin,
    output logic [XLEN-1:0] sig_end,
    output logic            halted,
    output logic            pass,
    output logic [XLEN-1:0] fail_code,
    output logic            timeout,
    output logic            con_valid,
    output logic [7:0]      con_data,
    input  logic            con_ready
);

    localparam int unsigned     BYTES   = XLEN / 8;
    localparam int unsigned     SHIFT   = $clog2(BYTES);
    localparam logic [XLEN-1:0] SPAN    = XLEN'(5 * BYTES);
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [XLEN-1:0] WD_LAST = XLEN'(TIMEOUT_CYCLES) - XLEN'(1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] sig_begin_q, sig_begin_d;
    logic [XLEN-1:0] sig_end_q, sig_end_d;
    logic [XLEN-1:0] cycle_q, cycle_d;
    logic [XLEN-1:0] fail_q, fail_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            pass_q, pass_d;
    logic            timeout_q, timeout_d;

    logic [XLEN-1:0] addr_off;
    logic [2:0]      idx;
    logic            wr_en;
    logic            halt_req;
    logic            wd_fire;
    logic            cnt_en;
    logic            wr_open;
    logic            fifo_empty;
    logic            con_overflow;
    logic [XLEN-1:0] rd_val;

    // Address decode: addresses below BASE_ADDR wrap to a large offset and miss.
    assign addr_off = address - BASE_ADDR;
    assign hit      = (addr_off <= SPAN);
    assign idx      = 3'(addr_off >> SHIFT);

    // Register writes are only honoured while the test is still running.
    assign wr_en    = store && hit && wr_open;
    assign halt_req = wr_en && (idx == 3'd0) && store_data[0];
    assign wd_fire  = WD_EN && cnt_en && (cycle_q == WD_LAST);

`ifdef SIM_CTRL_CONSOLE_EN
    localparam int unsigned PW = $clog2(CON_DEPTH);

    logic [7:0]  fifo_q [CON_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0] count_q;
    logic        overflow_q;
    logic        push, pop, full, accept;

    assign full       = (count_q == (PW+1)'(CON_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && con_ready;
    assign push       = wr_en && (idx == 3'd5);
    // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
    assign accept     = push && (!full || pop);

    // Console FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(CON_DEPTH); i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= store_data[7:0];
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign con_valid    = !fifo_empty;
    assign con_data     = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign con_overflow = overflow_q;
`else
    logic unused_con;

    assign fifo_empty   = 1'b1;
    assign con_valid    = 1'b0;
    assign con_data     = 8'h00;
    assign con_overflow = 1'b0;
    assign unused_con   = con_ready & (CON_DEPTH != 0);
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // FSM next state: a HALT write beats the watchdog; DRAIN waits for the console to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt_req)     state_d = fifo_empty ? S_HALTED : S_DRAIN;
                else if (wd_fire) state_d = S_HALTED;
            end
            S_DRAIN: begin
                if (wd_fire || fifo_empty) state_d = S_HALTED;
            end
            default: state_d = S_HALTED;
        endcase
    end

    // FSM outputs: halted flag, counter enable and write window.
    always_comb begin
        halted  = (state_q == S_HALTED);
        cnt_en  = (state_q != S_HALTED);
        wr_open = (state_q == S_RUN);
    end

    // Read mux; write-only and unmapped slots read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            3'd1:    rd_val = sig_begin_q;
            3'd2:    rd_val = sig_end_q;
            3'd3:    rd_val = cycle_q;
            3'd4:    rd_val = {{(XLEN-4){1'b0}}, con_overflow, timeout_q, pass_q, halted};
            default: rd_val = '0;
        endcase
    end

    // Next-state for the datapath registers: signature, cycle counter, halt outcome, read data.
    always_comb begin
        sig_begin_d = sig_begin_q;
        sig_end_d   = sig_end_q;
        cycle_d     = cycle_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        rdata_d     = rdata_q;

        if (wr_en && (idx == 3'd1)) sig_begin_d = store_data >> 1;
        if (wr_en && (idx == 3'd2))
            sig_end_d = (store_data < XLEN'(2)) ? '0 : (store_data >> 1) - XLEN'(1);

        if (cnt_en && (cycle_q != '1)) cycle_d = cycle_q + XLEN'(1);

        // The outcome is captured at the HALT write even if DRAIN delays halted.
        if (halt_req) begin
            pass_d = (store_data == XLEN'(1));
            fail_d = (store_data == XLEN'(1)) ? '0 : (store_data >> 1);
        end else if (wd_fire) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            fail_d    = '0;
        end

        // Reads see the pre-write value when load and store hit the same register.
        if (load && hit) rdata_d = rd_val;
    end

    // Datapath register bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_begin_q <= '0;
            sig_end_q   <= '0;
            cycle_q     <= '0;
            pass_q      <= 1'b0;
            fail_q      <= '0;
            timeout_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sig_begin_q <= sig_begin_d;
            sig_end_q   <= sig_end_d;
            cycle_q     <= cycle_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign sig_begin = sig_begin_q;
    assign sig_end   = sig_end_q;
    assign pass      = pass_q;
    assign fail_code = fail_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Directed bench for sim_ctrl_mmio: register map, halt outcomes, cycle counter,
// watchdog (second instance with TIMEOUT_CYCLES=16), console FIFO when built
// with SIM_CTRL_CONSOLE_EN, and asynchronous reset.
module tb_sim_ctrl_mmio;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        store, load, con_ready;
    logic [31:0] address, store_data;
    logic        hit, halted, pass, timeout, con_valid;
    logic [31:0] rdata, sig_begin, sig_end, fail_code;
    logic [7:0]  con_data;

    logic        w_reset = 1'b1;
    logic        w_store, w_load, w_con_ready;
    logic [31:0] w_address, w_store_data;
    logic        w_hit, w_halted, w_pass, w_timeout, w_con_valid;
    logic [31:0] w_rdata, w_sig_begin, w_sig_end, w_fail_code;
    logic [7:0]  w_con_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_pend;
    int unsigned exp_cyc = 0;
    bit          m_halt = 1'b0;

    sim_ctrl_mmio #(.XLEN(32), .BASE_ADDR(32'h2000_0000), .TIMEOUT_CYCLES(1000000), .CON_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .store(store), .load(load),
        .address(address), .store_data(store_data), .hit(hit), .rdata(rdata),
        .sig_begin(sig_begin), .sig_end(sig_end), .halted(halted), .pass(pass),
        .fail_code(fail_code), .timeout(timeout), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready)
    );

    sim_ctrl_mmio #(.XLEN(32), .BASE_ADDR(32'h2000_0000), .TIMEOUT_CYCLES(16), .CON_DEPTH(4)) dut_wd (
        .clock(clock), .reset(w_reset), .store(w_store), .load(w_load),
        .address(w_address), .store_data(w_store_data), .hit(w_hit), .rdata(w_rdata),
        .sig_begin(w_sig_begin), .sig_end(w_sig_end), .halted(w_halted), .pass(w_pass),
        .fail_code(w_fail_code), .timeout(w_timeout), .con_valid(w_con_valid),
        .con_data(w_con_data), .con_ready(w_con_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected CYCLE value: counts every edge out of reset until the bench halts the DUT.
    always @(posedge clock or posedge reset) begin
        if (reset)        exp_cyc <= 0;
        else if (!m_halt) exp_cyc <= exp_cyc + 1;
    end

    // Scoreboard: a read issued on one cycle is compared on the following negedge.
    always @(posedge clock or posedge reset) begin
        if (reset) rd_pend <= 1'b0;
        else       rd_pend <= load && hit;
    end

    always @(negedge clock) begin
        if (rd_pend) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input int k, input logic [31:0] d);
        store = 1'b1; address = BASE + 32'(k * 4); store_data = d;
        @(negedge clock);
        store = 1'b0;
    endtask

    task automatic rd(input int k, input logic [31:0] e, input string tag);
        load = 1'b1; address = BASE + 32'(k * 4);
        exp_q.push_back(e); tag_q.push_back(tag);
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; m_halt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        store = 0; load = 0; address = 0; store_data = 0; con_ready = 0;
        w_store = 0; w_load = 0; w_address = 0; w_store_data = 0; w_con_ready = 0;

        @(negedge clock);
        check("rst_halted", halted, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail_code, 0);
        check("rst_timeout", timeout, 0);
        check("rst_sig_begin", sig_begin, 0);
        check("rst_sig_end", sig_end, 0);
        check("rst_rdata", rdata, 0);
        check("rst_con_valid", con_valid, 0);
        reset = 1'b0;

        idle(3);
        rd(3, exp_cyc, "cycle_run");

        address = BASE + 32'd20; #1 check("hit_top", hit, 1);
        address = BASE + 32'd24; #1 check("hit_above", hit, 0);
        address = BASE - 32'd4;  #1 check("hit_below", hit, 0);
        address = 0;
        idle(1);

        wr(1, 32'h2000); check("sig_begin_wr", sig_begin, 32'h1000);
        wr(2, 32'h2100); check("sig_end_wr", sig_end, 32'h107F);
        rd(1, 32'h1000, "rd_sig_begin");
        rd(2, 32'h107F, "rd_sig_end");
        wr(2, 32'h1); check("sig_end_sat", sig_end, 0);
        wr(4, 32'hF);
        rd(4, 32'h0, "status_ro");
        rd(0, 32'h0, "halt_wo");

        load = 1; store = 1; address = BASE + 32'd4; store_data = 32'h4000;
        exp_q.push_back(32'h1000); tag_q.push_back("rd_old_value");
        @(negedge clock);
        load = 0; store = 0;
        check("sig_begin_same_cycle", sig_begin, 32'h2000);

`ifndef SIM_CTRL_CONSOLE_EN
        wr(5, 32'h61);
        check("con_valid_off", con_valid, 0);
        check("con_data_off", con_data, 0);
        rd(4, 32'h0, "status_con_off");
`endif

        wr(0, 32'h2); check("halt_bit0_clear", halted, 0);
        wr(0, 32'h0B); m_halt = 1'b1;
        check("fail_halted", halted, 1);
        check("fail_pass", pass, 0);
        check("fail_code", fail_code, 32'h5);
        rd(4, 32'h1, "status_fail");
        rd(3, exp_cyc, "cycle_frozen_a");
        idle(3);
        rd(3, exp_cyc, "cycle_frozen_b");
        wr(0, 32'h7);
        check("absorb_pass", pass, 0);
        check("absorb_fail", fail_code, 32'h5);
        wr(1, 32'h8000); check("absorb_sig", sig_begin, 32'h2000);

        do_reset();
        check("rerun_halted", halted, 0);
        wr(1, 32'h2000);
        wr(0, 32'h1); m_halt = 1'b1;
        check("pass_halted", halted, 1);
        check("pass_pass", pass, 1);
        check("pass_fail", fail_code, 0);
        check("pass_timeout", timeout, 0);
        rd(4, 32'h3, "status_pass");
        rd(3, exp_cyc, "cycle_pass");

        #2 reset = 1'b1;
        #1;
        check("async_halted", halted, 0);
        check("async_pass", pass, 0);
        check("async_sig_begin", sig_begin, 0);
        check("async_rdata", rdata, 0);
        m_halt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rd(3, 32'd0, "cycle_restart");

`ifdef SIM_CTRL_CONSOLE_EN
        do_reset();
        for (int i = 0; i < 5; i++) wr(5, 32'(8'h61 + 8'(i)));
        check("con_valid_full", con_valid, 1);
        check("con_head", con_data, 32'h61);
        rd(4, 32'h8, "status_ovf");
        wr(0, 32'h1);
        check("drain_halted", halted, 0);
        check("drain_pass", pass, 1);
        con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_byte", con_data, 32'(8'h61 + 8'(i)));
            check("drain_not_halted", halted, 0);
            @(negedge clock);
        end
        check("drain_empty", con_valid, 0);
        check("drain_still", halted, 0);
        @(negedge clock);
        check("drain_done", halted, 1);
        con_ready = 1'b0;

        do_reset();
        wr(5, 32'h78); wr(5, 32'h79); wr(0, 32'h1);
        check("drain2_halted", halted, 0);
        check("drain2_valid", con_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("drain_rst_valid", con_valid, 0);
        check("drain_rst_data", con_data, 0);
        check("drain_rst_pass", pass, 0);
        check("drain_rst_halted", halted, 0);
        m_halt = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rd(3, 32'd0, "cycle_restart_drain");
`endif

        @(negedge clock);
        w_reset = 1'b0;
        repeat (15) @(negedge clock);
        check("wd_before", w_halted, 0);
        @(negedge clock);
        check("wd_halted", w_halted, 1);
        check("wd_timeout", w_timeout, 1);
        check("wd_pass", w_pass, 0);
        check("wd_fail", w_fail_code, 0);

        w_reset = 1'b1;
        @(negedge clock);
        w_reset = 1'b0;
        repeat (15) @(negedge clock);
        w_store = 1'b1; w_address = BASE; w_store_data = 32'h1;
        @(negedge clock);
        w_store = 1'b0;
        check("tie_halted", w_halted, 1);
        check("tie_pass", w_pass, 1);
        check("tie_timeout", w_timeout, 0);
        idle(2);
        check("tie_timeout_hold", w_timeout, 0);

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
